spi_tx_sched: RTL and testbench

Round-robin transmit scheduler in front of the SPI transmitter. Shares the single SPI frame interface (`tx_data`/`dv`) among `NREQ` requesters and a built-in periodic heartbeat source. Launches one frame at a time, waits for the transmitter's completion pulse, and enforces an idle gap between frames. Generates the transmitter's active-low reset pulse after system reset.

---
 rtl/spi_tx_sched.sv | 179 +++++++++++++++++
 tb/tb_spi_tx_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_sched.sv
// Round-robin SPI frame scheduler: shares one tx_data/dv port among NREQ requesters plus a heartbeat.
// Optional WAIT watchdog enabled by defining SPI_TX_SCHED_TIMEOUT_EN.
module spi_tx_sched #(
  parameter int NREQ      = 4,
  parameter int DW        = 16,
  parameter int GAP       = 2,
  parameter int HB_PERIOD = 1937,
  parameter int TIMEOUT   = 4096
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic [NREQ-1:0]            req_valid_i,
  input  logic [NREQ*DW-1:0]         req_data_i,
  output logic [NREQ-1:0]            req_ready_o,
  output logic [DW-1:0]              tx_data_o,
  output logic                       dv_o,
  input  logic                       tx_done_i,
  output logic                       spi_reset_o,
  output logic [$clog2(NREQ+1)-1:0]  grant_id_o,
  output logic                       busy_o,
  output logic                       timeout_err_o
);
  localparam int GW  = $clog2(NREQ + 1);
  localparam int PW  = $clog2(NREQ);
  localparam int HBW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  localparam int GPW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [2:0] {ST_RST, ST_IDLE, ST_LAUNCH, ST_WAIT, ST_GAP} state_t;

  state_t          state_q;
  logic [PW-1:0]   ptr_q;
  logic [HBW-1:0]  hb_cnt_q;
  logic            hb_pending_q;
  logic [DW-1:0]   hb_seq_q;
  logic [GPW-1:0]  gap_cnt_q;
  logic [NREQ-1:0] req_ready_q;
  logic [DW-1:0]   tx_data_q;
  logic            dv_q;
  logic            spi_reset_q;
  logic [GW-1:0]   grant_id_q;
  logic            busy_q;

  logic            hb_tick_d;
  logic            sel_found_d;
  logic [PW-1:0]   sel_idx_d;
  logic [PW-1:0]   cand_d;
  logic [DW-1:0]   sel_word_d;

  assign hb_tick_d = (HB_PERIOD != 0) && (hb_cnt_q == HBW'(HB_PERIOD - 1));

  // Search starts just after the last granted requester and wraps.
  always_comb begin
    sel_found_d = 1'b0;
    sel_idx_d   = '0;
    cand_d      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_d = PW'((int'(ptr_q) + k) % NREQ);
      if (!sel_found_d && req_valid_i[cand_d]) begin
        sel_found_d = 1'b1;
        sel_idx_d   = cand_d;
      end
    end
  end

  always_comb begin
    sel_word_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel_idx_d == PW'(i)) sel_word_d = req_data_i[i*DW +: DW];
    end
  end

`ifdef SPI_TX_SCHED_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] wait_cnt_q;
  logic          timeout_err_q;
  assign timeout_err_o = timeout_err_q;
`else
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q      <= ST_RST;
      ptr_q        <= PW'(NREQ - 1);
      hb_cnt_q     <= '0;
      hb_pending_q <= 1'b0;
      hb_seq_q     <= '0;
      gap_cnt_q    <= '0;
      req_ready_q  <= '0;
      tx_data_q    <= '0;
      dv_q         <= 1'b0;
      spi_reset_q  <= 1'b0;
      grant_id_q   <= '0;
      busy_q       <= 1'b0;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
      wait_cnt_q    <= '0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      if (HB_PERIOD != 0) hb_cnt_q <= hb_tick_d ? '0 : hb_cnt_q + 1'b1;
      if (hb_tick_d) hb_pending_q <= 1'b1;
      spi_reset_q <= 1'b1;
      dv_q        <= 1'b0;
      req_ready_q <= '0;
      case (state_q)
        ST_RST: state_q <= ST_IDLE;
        ST_IDLE: begin
          if (hb_pending_q) begin
            // Later write wins, so a tick colliding with this launch is dropped.
            hb_pending_q <= 1'b0;
            tx_data_q    <= hb_seq_q;
            hb_seq_q     <= hb_seq_q + 1'b1;
            grant_id_q   <= GW'(NREQ);
            dv_q         <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= ST_LAUNCH;
          end else if (sel_found_d) begin
            tx_data_q   <= sel_word_d;
            grant_id_q  <= GW'(sel_idx_d);
            req_ready_q <= NREQ'(1) << sel_idx_d;
            ptr_q       <= sel_idx_d;
            dv_q        <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_WAIT;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
          wait_cnt_q <= '0;
`endif
        end
        ST_WAIT: begin
          if (tx_done_i) begin
            if (GAP == 0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= GPW'(GAP - 1);
            end
          end
`ifdef SPI_TX_SCHED_TIMEOUT_EN
          else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
            spi_reset_q   <= 1'b0;
            timeout_err_q <= 1'b1;
            if (GAP == 0) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= ST_GAP;
              gap_cnt_q <= GPW'(GAP - 1);
            end
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end
        default: state_q <= ST_RST;
      endcase
    end
  end

  assign req_ready_o = req_ready_q;
  assign tx_data_o   = tx_data_q;
  assign dv_o        = dv_q;
  assign spi_reset_o = spi_reset_q;
  assign grant_id_o  = grant_id_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_spi_tx_sched.sv
// Directed bench for spi_tx_sched: one instance with heartbeat off, one with HB_PERIOD=20.
module tb_spi_tx_sched;
  localparam int NREQ = 4;
  localparam int DW   = 16;
  localparam int GAP  = 2;
  localparam int GW   = $clog2(NREQ + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              a_rst_n, a_done, a_dv, a_spi, a_busy, a_terr;
  logic [NREQ-1:0]   a_valid, a_ready;
  logic [NREQ*DW-1:0] a_data;
  logic [DW-1:0]     a_txd;
  logic [GW-1:0]     a_gid;
  logic              b_rst_n, b_done, b_dv, b_spi, b_busy, b_terr;
  logic [NREQ-1:0]   b_valid, b_ready;
  logic [NREQ*DW-1:0] b_data;
  logic [DW-1:0]     b_txd;
  logic [GW-1:0]     b_gid;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  spi_tx_sched #(.NREQ(NREQ), .DW(DW), .GAP(GAP), .HB_PERIOD(0), .TIMEOUT(16)) u_dut (
    .clk_i(clk), .reset_i(a_rst_n), .req_valid_i(a_valid), .req_data_i(a_data),
    .req_ready_o(a_ready), .tx_data_o(a_txd), .dv_o(a_dv), .tx_done_i(a_done),
    .spi_reset_o(a_spi), .grant_id_o(a_gid), .busy_o(a_busy), .timeout_err_o(a_terr));

  spi_tx_sched #(.NREQ(NREQ), .DW(DW), .GAP(GAP), .HB_PERIOD(20), .TIMEOUT(4096)) u_hb (
    .clk_i(clk), .reset_i(b_rst_n), .req_valid_i(b_valid), .req_data_i(b_data),
    .req_ready_o(b_ready), .tx_data_o(b_txd), .dv_o(b_dv), .tx_done_i(b_done),
    .spi_reset_o(b_spi), .grant_id_o(b_gid), .busy_o(b_busy), .timeout_err_o(b_terr));

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic wait_dv(input bit sel, input int max, output bit seen, output int n);
    seen = 1'b0;
    n = 0;
    while (!seen && n < max) begin
      step();
      n++;
      seen = sel ? b_dv : a_dv;
    end
  endtask

  task automatic test_reset();
    a_rst_n = 0; b_rst_n = 0;
    a_valid = '0; b_valid = '0; a_data = '0; b_data = '0; a_done = 0; b_done = 0;
    repeat (10) step();
    n_checks++; if (a_spi !== 1'b0) begin n_fail++; $display("FAIL rst_spi_reset got %b want 0", a_spi); end
    n_checks++; if (a_dv !== 1'b0) begin n_fail++; $display("FAIL rst_dv got %b want 0", a_dv); end
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", a_busy); end
    n_checks++; if (a_gid !== '0) begin n_fail++; $display("FAIL rst_grant_id got %0d want 0", a_gid); end
    n_checks++; if (a_ready !== '0) begin n_fail++; $display("FAIL rst_req_ready got %b want 0", a_ready); end
    n_checks++; if (a_txd !== '0) begin n_fail++; $display("FAIL rst_tx_data got %h want 0", a_txd); end
    n_checks++; if (a_terr !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err got %b want 0", a_terr); end
    n_checks++; if (b_spi !== 1'b0) begin n_fail++; $display("FAIL rst_hb_spi_reset got %b want 0", b_spi); end
    a_rst_n = 1;
    #1;
    n_checks++; if (a_spi !== 1'b0) begin n_fail++; $display("FAIL rst_cycle_spi_reset got %b want 0", a_spi); end
    step();
    n_checks++; if (a_spi !== 1'b1) begin n_fail++; $display("FAIL post_rst_spi_reset got %b want 1", a_spi); end
    repeat (5) begin
      step();
      n_checks++; if (a_dv !== 1'b0 || a_ready !== '0) begin n_fail++; $display("FAIL idle_no_grant dv %b ready %b want 0 0", a_dv, a_ready); end
    end
  endtask

  task automatic test_single_grant();
    a_data[2*DW +: DW] = 16'hA5A5;
    a_valid = 4'b0100;
    step();
    n_checks++; if (a_ready !== 4'b0100) begin n_fail++; $display("FAIL sg_req_ready got %b want 0100", a_ready); end
    n_checks++; if (a_dv !== 1'b1) begin n_fail++; $display("FAIL sg_dv got %b want 1", a_dv); end
    n_checks++; if (a_txd !== 16'hA5A5) begin n_fail++; $display("FAIL sg_tx_data got %h want a5a5", a_txd); end
    n_checks++; if (a_gid !== 3'd2) begin n_fail++; $display("FAIL sg_grant_id got %0d want 2", a_gid); end
    n_checks++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL sg_busy got %b want 1", a_busy); end
    a_valid = 4'b1000;
    a_data[3*DW +: DW] = 16'h1234;
    step();
    n_checks++; if (a_dv !== 1'b0 || a_ready !== '0) begin n_fail++; $display("FAIL sg_wait_dv dv %b ready %b want 0 0", a_dv, a_ready); end
    repeat (3) begin
      step();
      n_checks++; if (a_dv !== 1'b0) begin n_fail++; $display("FAIL sg_early_dv got %b want 0", a_dv); end
    end
    n_checks++; if (a_txd !== 16'hA5A5) begin n_fail++; $display("FAIL sg_tx_data_hold got %h want a5a5", a_txd); end
    a_done = 1;
    for (int k = 1; k <= GAP + 1; k++) begin
      step();
      a_done = 0;
      n_checks++; if (a_dv !== 1'b0) begin n_fail++; $display("FAIL sg_gap_dv at d+%0d got %b want 0", k, a_dv); end
    end
    step();
    n_checks++; if (a_dv !== 1'b1) begin n_fail++; $display("FAIL sg_second_dv got %b want 1", a_dv); end
    n_checks++; if (a_gid !== 3'd3 || a_txd !== 16'h1234) begin n_fail++; $display("FAIL sg_second_word gid %0d data %h want 3 1234", a_gid, a_txd); end
    n_checks++; if (a_ready !== 4'b1000) begin n_fail++; $display("FAIL sg_second_ready got %b want 1000", a_ready); end
    a_valid = '0;
    step();
    a_done = 1;
    step();
    a_done = 0;
    repeat (GAP + 1) step();
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL sg_idle_busy got %b want 0", a_busy); end
  endtask

  task automatic test_round_robin();
    int ord[6] = '{0, 1, 2, 3, 0, 1};
    bit seen;
    int n;
    a_data = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    a_valid = 4'hF;
    for (int i = 0; i < 6; i++) begin
      wait_dv(1'b0, 20, seen, n);
      n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rr_dv_timeout frame %0d got none want dv", i); end
      if (seen) begin
        n_checks++; if (a_gid !== GW'(ord[i])) begin n_fail++; $display("FAIL rr_grant_id frame %0d got %0d want %0d", i, a_gid, ord[i]); end
        n_checks++; if (a_ready !== (4'b0001 << ord[i])) begin n_fail++; $display("FAIL rr_ready frame %0d got %b want onehot %0d", i, a_ready, ord[i]); end
        n_checks++; if (a_txd !== 16'h1000 + 16'(ord[i])) begin n_fail++; $display("FAIL rr_tx_data frame %0d got %h", i, a_txd); end
        if (i > 0) begin
          n_checks++; if (n !== GAP + 1) begin n_fail++; $display("FAIL rr_spacing frame %0d got %0d want %0d", i, n, GAP + 1); end
        end
      end
      if (i == 5) a_valid = '0;
      for (int k = 1; k <= 5; k++) begin
        step();
        n_checks++; if (a_dv !== 1'b0 || a_ready !== '0) begin n_fail++; $display("FAIL rr_quiet frame %0d dv %b ready %b want 0 0", i, a_dv, a_ready); end
      end
      a_done = 1;
      step();
      a_done = 0;
    end
    repeat (GAP + 1) step();
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL rr_idle_busy got %b want 0", a_busy); end
  endtask

  task automatic test_heartbeat();
    bit seen;
    int n, c0;
    b_rst_n = 1;
    c0 = cyc;
    repeat (20) step();
    n_checks++; if (b_dv !== 1'b0 || b_busy !== 1'b0) begin n_fail++; $display("FAIL hb_pre_tick dv %b busy %b want 0 0", b_dv, b_busy); end
    b_valid = 4'b0010;
    b_data[1*DW +: DW] = 16'hBEEF;
    step();
    n_checks++; if (b_dv !== 1'b1) begin n_fail++; $display("FAIL hb_first_dv got %b want 1", b_dv); end
    n_checks++; if (b_gid !== 3'd4 || b_txd !== 16'h0000) begin n_fail++; $display("FAIL hb_first_word gid %0d data %h want 4 0000", b_gid, b_txd); end
    n_checks++; if (b_ready !== '0) begin n_fail++; $display("FAIL hb_no_ready got %b want 0", b_ready); end
    step();
    b_done = 1;
    step();
    b_done = 0;
    wait_dv(1'b1, 20, seen, n);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL hb_req1_timeout got none want dv"); end
    n_checks++; if (b_gid !== 3'd1 || b_txd !== 16'hBEEF || b_ready !== 4'b0010) begin n_fail++; $display("FAIL hb_req1 gid %0d data %h ready %b want 1 beef 0010", b_gid, b_txd, b_ready); end
    b_valid = '0;
    step();
    b_done = 1;
    step();
    b_done = 0;
    wait_dv(1'b1, 40, seen, n);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL hb_second_timeout got none want dv"); end
    n_checks++; if (b_gid !== 3'd4 || b_txd !== 16'h0001) begin n_fail++; $display("FAIL hb_second_word gid %0d data %h want 4 0001", b_gid, b_txd); end
    n_checks++; if (cyc - c0 !== 41) begin n_fail++; $display("FAIL hb_second_time got %0d want 41", cyc - c0); end
    step();
    b_done = 1;
    step();
    b_done = 0;
  endtask

  task automatic test_reset_in_wait();
    bit seen;
    int n;
    a_valid = 4'b0100;
    wait_dv(1'b0, 10, seen, n);
    n_checks++; if (seen !== 1'b1 || a_gid !== 3'd2) begin n_fail++; $display("FAIL riw_pre_grant seen %b gid %0d want 1 2", seen, a_gid); end
    a_valid = '0;
    step();
    step();
    a_rst_n = 0;
    step();
    n_checks++; if (a_spi !== 1'b0 || a_dv !== 1'b0 || a_busy !== 1'b0) begin n_fail++; $display("FAIL riw_ctrl spi %b dv %b busy %b want 0 0 0", a_spi, a_dv, a_busy); end
    n_checks++; if (a_gid !== '0 || a_txd !== '0 || a_ready !== '0) begin n_fail++; $display("FAIL riw_data gid %0d data %h ready %b want 0 0 0", a_gid, a_txd, a_ready); end
    a_rst_n = 1;
    a_valid = 4'hF;
    step();
    n_checks++; if (a_spi !== 1'b1 || a_dv !== 1'b0) begin n_fail++; $display("FAIL riw_release spi %b dv %b want 1 0", a_spi, a_dv); end
    wait_dv(1'b0, 10, seen, n);
    n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL riw_dv_timeout got none want dv"); end
    n_checks++; if (a_gid !== 3'd0 || a_ready !== 4'b0001 || a_txd !== 16'h1000) begin n_fail++; $display("FAIL riw_first_grant gid %0d ready %b data %h want 0 0001 1000", a_gid, a_ready, a_txd); end
    a_valid = '0;
    step();
    a_done = 1;
    step();
    a_done = 0;
    repeat (GAP + 1) step();
  endtask

  task automatic test_watchdog();
    bit seen;
    int n;
    a_valid = 4'b0010;
    wait_dv(1'b0, 10, seen, n);
    n_checks++; if (seen !== 1'b1 || a_gid !== 3'd1) begin n_fail++; $display("FAIL wd_grant seen %b gid %0d want 1 1", seen, a_gid); end
    a_valid = '0;
    a_done = 1;
    step();
    a_done = 0;
`ifdef SPI_TX_SCHED_TIMEOUT_EN
    repeat (15) begin
      step();
      n_checks++; if (a_spi !== 1'b1 || a_busy !== 1'b1) begin n_fail++; $display("FAIL wd_waiting spi %b busy %b want 1 1", a_spi, a_busy); end
    end
    step();
    n_checks++; if (a_spi !== 1'b0 || a_terr !== 1'b1) begin n_fail++; $display("FAIL wd_fire spi %b terr %b want 0 1", a_spi, a_terr); end
    step();
    n_checks++; if (a_spi !== 1'b1 || a_busy !== 1'b1) begin n_fail++; $display("FAIL wd_after spi %b busy %b want 1 1", a_spi, a_busy); end
    step();
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL wd_busy_drop got %b want 0", a_busy); end
    a_valid = 4'b0100;
    wait_dv(1'b0, 10, seen, n);
    n_checks++; if (seen !== 1'b1 || a_gid !== 3'd2 || a_terr !== 1'b1) begin n_fail++; $display("FAIL wd_next seen %b gid %0d terr %b want 1 2 1", seen, a_gid, a_terr); end
    a_valid = '0;
    step();
`else
    repeat (40) step();
    n_checks++; if (a_busy !== 1'b1 || a_dv !== 1'b0) begin n_fail++; $display("FAIL wd_hold busy %b dv %b want 1 0", a_busy, a_dv); end
    n_checks++; if (a_terr !== 1'b0 || a_spi !== 1'b1) begin n_fail++; $display("FAIL wd_off terr %b spi %b want 0 1", a_terr, a_spi); end
`endif
    a_done = 1;
    step();
    a_done = 0;
    repeat (GAP + 1) step();
    n_checks++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL wd_end_busy got %b want 0", a_busy); end
  endtask

  initial begin
    test_reset();
    test_single_grant();
    test_round_robin();
    test_heartbeat();
    test_reset_in_wait();
    test_watchdog();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "bench timeout");
  end
endmodule
